ttl_74597_sync: RTL and testbench

- Single-clock parallel-in/serial-out shift register with an input storage register, modelled on the 74597.
- It is the transmit end for the serial-in parts (74164/74595-style receivers): it captures a parallel word, then shifts it out MSB-first.
- A bit counter and Busy flag let a bench or a controlling block frame each word without external counting.
- It sits alongside the gate-level parts and reuses their DELAY_RISE/DELAY_FALL output-delay convention.

---
 rtl/ttl_597_storage.sv | 27 ++
 rtl/ttl_74597_sync.sv | 62 ++++++
 tb/tb_ttl_74597_sync.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ttl_597_storage.sv
// Input storage register for the 74597-style transmitter: a WIDTH-bit
// enable register with synchronous active-low clear.
module ttl_597_storage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_bar,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stor_d, stor_q;

  always_comb begin
    stor_d = stor_q;
    if (en) stor_d = d;
  end

  always_ff @(posedge clk) begin
    if (!clear_bar) stor_q <= '0;
    else            stor_q <= stor_d;
  end

  assign q = stor_q;

endmodule

// File: rtl/ttl_74597_sync.sv
// 74597-style parallel-in/serial-out shifter with input storage register,
// MSB-first, with a remaining-bit counter and Busy flag for word framing.
module ttl_74597_sync #(
  parameter int WIDTH      = 8,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                       Clk,
  input  logic                       Clear_bar,
  input  logic [WIDTH-1:0]           D,
  input  logic                       Store,
  input  logic                       Load_bar,
  input  logic                       Shift,
  input  logic                       DS,
  output logic                       Q,
  output logic [$clog2(WIDTH+1)-1:0] Count,
  output logic                       Busy
);

  localparam int CW = $clog2(WIDTH+1);

  logic [WIDTH-1:0] stor_q;
  logic [WIDTH-1:0] sr_d, sr_q;
  logic [CW-1:0]    cnt_d, cnt_q;

  ttl_597_storage #(.WIDTH(WIDTH)) u_storage (
    .clk       (Clk),
    .clear_bar (Clear_bar),
    .en        (Store),
    .d         (D),
    .q         (stor_q)
  );

  // Load sees the storage value from before this edge, so Store+Load on
  // the same edge pipelines two words back to back.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (!Load_bar) begin
      sr_d  = stor_q;
      cnt_d = CW'(WIDTH);
    end else if (Shift) begin
      sr_d = {sr_q[WIDTH-2:0], DS};
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clear_bar) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign #(DELAY_RISE, DELAY_FALL) Q     = sr_q[WIDTH-1];
  assign #(DELAY_RISE, DELAY_FALL) Count = cnt_q;
  assign #(DELAY_RISE, DELAY_FALL) Busy  = (cnt_q != '0);

endmodule

// File: tb/tb_ttl_74597_sync.sv
// Directed, table-driven bench for ttl_74597_sync (WIDTH=8, delays 5/3).
module tb_ttl_74597_sync;

  logic       Clk = 1'b0;
  logic       Clear_bar, Store, Load_bar, Shift, DS;
  logic [7:0] D;
  logic       Q, Busy;
  logic [3:0] Count;

  int checks = 0;
  int errors = 0;

  ttl_74597_sync #(.WIDTH(8), .DELAY_RISE(5), .DELAY_FALL(3)) dut (
    .Clk(Clk), .Clear_bar(Clear_bar), .D(D), .Store(Store),
    .Load_bar(Load_bar), .Shift(Shift), .DS(DS),
    .Q(Q), .Count(Count), .Busy(Busy)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       clr_n, store, load_n, shift, ds;
    logic [7:0] d;
    logic       exp_q;
    logic [3:0] exp_cnt;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic clr_n, logic store, logic load_n,
                              logic shift, logic ds, logic [7:0] d,
                              logic eq, logic [3:0] ec, logic eb);
    vec_t v;
    v.name = name; v.clr_n = clr_n; v.store = store; v.load_n = load_n;
    v.shift = shift; v.ds = ds; v.d = d;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_busy = eb;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs while Clk is low, take the edge, sample 10 units later.
  task automatic step(logic clr_n, logic store, logic load_n, logic shift,
                      logic ds, logic [7:0] d);
    Clear_bar = clr_n; Store = store; Load_bar = load_n;
    Shift = shift; DS = ds; D = d;
    @(posedge Clk);
    #10;
  endtask

  task automatic chk_out(string name, logic eq, logic [3:0] ec, logic eb);
    chk({name, ".Q"},     {7'd0, Q},     {7'd0, eq});
    chk({name, ".Count"}, {4'd0, Count}, {4'd0, ec});
    chk({name, ".Busy"},  {7'd0, Busy},  {7'd0, eb});
  endtask

  // Q after shifts 1..8, MSB = shift 1
  localparam logic [7:0] A5_SEQ   = 8'b0100_1010;
  localparam logic [7:0] DRAIN3C  = 8'b0111_1000;
  localparam logic [7:0] IDLE_SEQ = 8'b0000_0001;

  initial begin
    Clear_bar = 1'b1; Store = 1'b0; Load_bar = 1'b1;
    Shift = 1'b0; DS = 1'b0; D = 8'h00;

    // reset overrides store/load/shift; later load proves storage cleared
    add("reset",        0, 1, 0, 1, 0, 8'hFF, 0, 4'd0, 0);
    add("load_cleared", 1, 0, 0, 0, 0, 8'h00, 0, 4'd8, 1);
    add("store_A5",     1, 1, 1, 0, 0, 8'hA5, 0, 4'd8, 1);
    add("load_A5",      1, 0, 0, 0, 0, 8'h00, 1, 4'd8, 1);
    for (int i = 0; i < 8; i++)
      add($sformatf("shift_A5_%0d", i+1), 1, 0, 1, 1, 0, 8'h00,
          A5_SEQ[7-i], 4'(7-i), (i != 7));
    // pipelined store+load: shifter gets A5, storage gets 3C
    add("pipe_store_load", 1, 1, 0, 0, 0, 8'h3C, 1, 4'd8, 1);
    add("load_3C",         1, 0, 0, 0, 0, 8'h00, 0, 4'd8, 1);
    add("shift_3C_1",      1, 0, 1, 1, 0, 8'h00, 0, 4'd7, 1);
    add("shift_3C_2",      1, 0, 1, 1, 0, 8'h00, 1, 4'd6, 1);
    // load beats shift; reload mid-word restarts the count
    add("prio_load",       1, 0, 0, 1, 0, 8'h00, 0, 4'd8, 1);
    for (int i = 0; i < 8; i++)
      add($sformatf("drain_3C_%0d", i+1), 1, 0, 1, 1, 0, 8'h00,
          DRAIN3C[7-i], 4'(7-i), (i != 7));
    for (int i = 0; i < 8; i++)
      add($sformatf("idle_shift_%0d", i+1), 1, 0, 1, 1, 1, 8'h00,
          IDLE_SEQ[7-i], 4'd0, 0);
    add("hold", 1, 0, 1, 0, 0, 8'h00, 1, 4'd0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].clr_n, vecs[i].store, vecs[i].load_n,
           vecs[i].shift, vecs[i].ds, vecs[i].d);
      chk_out(vecs[i].name, vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_busy);
    end

    // reset mid-word abandons the word and clears storage
    step(1, 1, 1, 0, 0, 8'hFF);
    step(1, 0, 0, 0, 0, 8'h00);
    chk_out("mid_load_FF", 1, 4'd8, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 8'h00);
    chk_out("mid_shift3", 1, 4'd5, 1);
    step(0, 0, 1, 0, 0, 8'h00);
    chk_out("mid_reset", 0, 4'd0, 0);
    step(1, 0, 0, 0, 0, 8'h00);
    chk_out("mid_reload", 0, 4'd8, 1);

    // storage holds while Store is low, independent of shifting
    step(1, 1, 1, 1, 0, 8'h81);
    step(1, 0, 1, 1, 0, 8'h00);
    step(1, 0, 0, 0, 0, 8'h7E);
    chk_out("store_hold", 1, 4'd8, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 1, 0, 8'h00);
    chk_out("store_hold_lsb", 1, 4'd1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
